// File: rtl/cnt_pkg.sv
// Shared definitions for the N-digit counter: digit width, digit slicing and
// prescaler width.
package cnt_pkg;

  // Prescaler width; holds TICK_DIV-1 for TICK_DIV up to 2^20.
  localparam int unsigned TICK_W = 20;

  // Bits needed to hold one digit of the given radix.
  function automatic int unsigned digit_width(input int unsigned base);
    return ($clog2(base) < 1) ? 1 : $clog2(base);
  endfunction

  // LSB position of digit idx inside a packed multi-digit vector.
  function automatic int unsigned digit_lsb(input int unsigned idx, input int unsigned dw);
    return idx * dw;
  endfunction

endpackage

// File: rtl/cnt_digit.sv
// One counter digit: saturating load, up/down step gated by the incoming
// carry/borrow, combinational carry/borrow out for the next digit.
module cnt_digit
  import cnt_pkg::*;
#(
  parameter int unsigned BASE = 10,
  parameter int unsigned DW   = digit_width(BASE)
) (
  input  logic          CLOCK_50,
  input  logic          nreset,
  input  logic          load,
  input  logic [DW-1:0] ld_val,
  input  logic          step,
  input  logic          up,
  input  logic          cin,
  output logic [DW-1:0] digit,
  output logic          cout
);

  localparam logic [DW-1:0] MaxDigit = DW'(BASE - 1);

  logic [DW-1:0] digit_d;
  logic          at_edge;

  // Digit sits at the value that rolls over in the current direction.
  assign at_edge = up ? (digit == MaxDigit) : (digit == '0);
  assign cout    = cin & at_edge;

  // Next digit value: load has priority, then a step when the chain reaches us.
  always_comb begin
    digit_d = digit;
    if (load) begin
      digit_d = (ld_val > MaxDigit) ? MaxDigit : ld_val;
    end else if (step && cin) begin
      if (up) begin
        digit_d = at_edge ? '0 : digit + DW'(1);
      end else begin
        digit_d = at_edge ? MaxDigit : digit - DW'(1);
      end
    end
  end

  // Digit register.
  always_ff @(posedge CLOCK_50 or negedge nreset) begin
    if (!nreset) begin
      digit <= '0;
    end else begin
      digit <= digit_d;
    end
  end

endmodule

// File: rtl/cnt_ndigits.sv
// Multi-digit up/down counter with prescaler, wrap pulse, sticky overflow
// and optional leading-zero blank mask (enabled by defining CNT_LZ_BLANK_EN).
module cnt_ndigits
  import cnt_pkg::*;
#(
  parameter int unsigned BASE     = 10,
  parameter int unsigned DIGITS   = 5,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic                           CLOCK_50,
  input  logic                           nreset,
  input  logic                           enable,
  input  logic                           nload,
  input  logic                           up,
  input  logic [DIGITS*digit_width(BASE)-1:0] load_val,
  output logic [DIGITS*digit_width(BASE)-1:0] count,
  output logic                           wrap,
  output logic                           ovf,
  output logic [DIGITS-1:0]              blank
);

  localparam int unsigned DW = digit_width(BASE);
  localparam logic [TICK_W-1:0] PreLast = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] pre_q, pre_d;
  logic              wrap_d, ovf_d;
  logic              pre_last, step, load;
  logic [DIGITS:0]   carry;

  assign load     = ~nload;
  assign pre_last = (pre_q == PreLast);
  assign step     = enable & nload & pre_last;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    cnt_digit #(
      .BASE(BASE),
      .DW  (DW)
    ) u_digit (
      .CLOCK_50(CLOCK_50),
      .nreset  (nreset),
      .load    (load),
      .ld_val  (load_val[digit_lsb(i, DW) +: DW]),
      .step    (step),
      .up      (up),
      .cin     (carry[i]),
      .digit   (count[digit_lsb(i, DW) +: DW]),
      .cout    (carry[i+1])
    );
  end

  // Prescaler, wrap pulse and sticky overflow next-state; load clears all.
  always_comb begin
    pre_d  = pre_q;
    wrap_d = 1'b0;
    ovf_d  = ovf;
    if (!nload) begin
      pre_d = '0;
      ovf_d = 1'b0;
    end else if (enable) begin
      pre_d = pre_last ? '0 : pre_q + TICK_W'(1);
      if (step && carry[DIGITS]) begin
        wrap_d = 1'b1;
        ovf_d  = 1'b1;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge CLOCK_50 or negedge nreset) begin
    if (!nreset) begin
      pre_q <= '0;
      wrap  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      pre_q <= pre_d;
      wrap  <= wrap_d;
      ovf   <= ovf_d;
    end
  end

`ifdef CNT_LZ_BLANK_EN
  // Reset count is all zero, so every digit but digit 0 is blanked.
  localparam logic [DIGITS-1:0] BlankRst = ~DIGITS'(1);

  logic [DIGITS-1:0] nxt_zero;
  logic [DIGITS-1:0] blank_d;
  logic [DW-1:0]     dig;
  logic              all_zero;

  // Predict which digits are zero after this edge so blank tracks count.
  always_comb begin
    nxt_zero = '0;
    dig      = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = count[digit_lsb(i, DW) +: DW];
      if (!nload) begin
        nxt_zero[i] = (load_val[digit_lsb(i, DW) +: DW] == '0);
      end else if (step && carry[i]) begin
        nxt_zero[i] = up ? (dig == DW'(BASE - 1)) : (dig == DW'(1));
      end else begin
        nxt_zero[i] = (dig == '0);
      end
    end
  end

  // Leading-zero mask from the top digit down; digit 0 is never blanked.
  always_comb begin
    blank_d  = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero   = all_zero & nxt_zero[i];
      blank_d[i] = all_zero;
    end
  end

  // Blank mask register.
  always_ff @(posedge CLOCK_50 or negedge nreset) begin
    if (!nreset) begin
      blank <= BlankRst;
    end else begin
      blank <= blank_d;
    end
  end
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_cnt_ndigits.sv
// Scoreboard bench for cnt_ndigits: one TICK_DIV=1 instance and one TICK_DIV=4
// instance, directed vectors with hand-computed expectations.
module tb_cnt_ndigits;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nr1, en1, nl1, up1, wr1, ov1;
  logic [19:0] lv1, cnt1;
  logic [4:0]  bl1;
  logic        nr4, en4, nl4, up4, wr4, ov4;
  logic [19:0] lv4, cnt4;
  logic [4:0]  bl4;

  cnt_ndigits #(.BASE(10), .DIGITS(5), .TICK_DIV(1)) u_dut1 (
    .CLOCK_50(clk), .nreset(nr1), .enable(en1), .nload(nl1), .up(up1),
    .load_val(lv1), .count(cnt1), .wrap(wr1), .ovf(ov1), .blank(bl1)
  );

  cnt_ndigits #(.BASE(10), .DIGITS(5), .TICK_DIV(4)) u_dut4 (
    .CLOCK_50(clk), .nreset(nr4), .enable(en4), .nload(nl4), .up(up4),
    .load_val(lv4), .count(cnt4), .wrap(wr4), .ovf(ov4), .blank(bl4)
  );

  typedef struct {
    string       name;
    int          dut;
    int          cyc;
    logic [19:0] cnt;
    logic        wrap;
    logic        ovf;
    logic [4:0]  bl;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Leading-zero mask expected for a BCD count.
  function automatic logic [4:0] blank_of(input logic [19:0] c);
    logic [4:0] b;
    logic       z;
    b = '0;
`ifdef CNT_LZ_BLANK_EN
    z = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      z    = z && (c[i*4 +: 4] == 4'h0);
      b[i] = z;
    end
`else
    z = 1'b0;
    b = {4'b0000, z};
`endif
    return b;
  endfunction

  task automatic push(input string n, input int d, input logic [19:0] c, input logic w,
                      input logic o, input logic [4:0] b);
    exp_t e;
    e.name = n; e.dut = d; e.cyc = cyc; e.cnt = c; e.wrap = w; e.ovf = o; e.bl = b;
    sb.push_back(e);
  endtask

  task automatic chk(input string n, input int d, input logic [19:0] c, input logic w,
                     input logic o);
    push(n, d, c, w, o, blank_of(c));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every due expectation against the DUT on the falling edge.
  exp_t        me;
  logic [19:0] a_cnt;
  logic        a_wr, a_ov;
  logic [4:0]  a_bl;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      me = sb.pop_front();
      if (me.dut == 1) begin
        a_cnt = cnt1; a_wr = wr1; a_ov = ov1; a_bl = bl1;
      end else begin
        a_cnt = cnt4; a_wr = wr4; a_ov = ov4; a_bl = bl4;
      end
      total++;
      if (a_cnt !== me.cnt || a_wr !== me.wrap || a_ov !== me.ovf || a_bl !== me.bl) begin
        bad++;
        $display("FAIL %s: got cnt=%h wrap=%b ovf=%b blank=%b, want cnt=%h wrap=%b ovf=%b blank=%b",
                 me.name, a_cnt, a_wr, a_ov, a_bl, me.cnt, me.wrap, me.ovf, me.bl);
      end
    end
  end

  task automatic load1(input logic [19:0] v);
    nl1 = 1'b0; lv1 = v; tick(); nl1 = 1'b1;
  endtask

  task automatic load4(input logic [19:0] v);
    nl4 = 1'b0; lv4 = v; tick(); nl4 = 1'b1;
  endtask

  initial begin
    nr1 = 1'b0; en1 = 1'b0; nl1 = 1'b1; up1 = 1'b1; lv1 = '0;
    nr4 = 1'b0; en4 = 1'b0; nl4 = 1'b1; up4 = 1'b1; lv4 = '0;
    tick();
    chk("reset1", 1, 20'h00000, 1'b0, 1'b0);
    chk("reset4", 2, 20'h00000, 1'b0, 1'b0);
    nr1 = 1'b1; nr4 = 1'b1;
    tick();

    // Up carry ripple and full wrap.
    load1(20'h00999); chk("load_00999", 1, 20'h00999, 1'b0, 1'b0);
    up1 = 1'b1; en1 = 1'b1; tick(); en1 = 1'b0;
    chk("up_carry", 1, 20'h01000, 1'b0, 1'b0);
    load1(20'h99999); chk("load_99999", 1, 20'h99999, 1'b0, 1'b0);
    en1 = 1'b1; tick(); en1 = 1'b0;
    chk("up_wrap", 1, 20'h00000, 1'b1, 1'b1);
    tick(); chk("wrap_one_cycle", 1, 20'h00000, 1'b0, 1'b1);
    load1(20'h00000); chk("load_clears_ovf", 1, 20'h00000, 1'b0, 1'b0);

    // Down wrap; changing up between steps has no effect.
    up1 = 1'b0; en1 = 1'b1; tick(); en1 = 1'b0;
    chk("down_wrap", 1, 20'h99999, 1'b1, 1'b1);
    up1 = 1'b1; tick(); chk("down_wrap_end", 1, 20'h99999, 1'b0, 1'b1);

    // Per-digit load saturation.
    load1(20'h0C123); chk("sat_digit", 1, 20'h09123, 1'b0, 1'b0);
    load1(20'hFFFFF); chk("sat_all", 1, 20'h99999, 1'b0, 1'b0);

    // Load beats enable, then normal steps and a borrow ripple.
    nl1 = 1'b0; en1 = 1'b1; up1 = 1'b1; lv1 = 20'h12345; tick();
    chk("load_wins", 1, 20'h12345, 1'b0, 1'b0);
    nl1 = 1'b1; tick(); chk("step_after_load", 1, 20'h12346, 1'b0, 1'b0);
    up1 = 1'b0; tick(); en1 = 1'b0; chk("down_step", 1, 20'h12345, 1'b0, 1'b0);
    load1(20'h10000);
    en1 = 1'b1; tick(); en1 = 1'b0; chk("borrow_ripple", 1, 20'h09999, 1'b0, 1'b0);

    // Leading-zero blanking.
    load1(20'h00070);
`ifdef CNT_LZ_BLANK_EN
    push("blank_00070", 1, 20'h00070, 1'b0, 1'b0, 5'b11100);
`else
    push("blank_00070", 1, 20'h00070, 1'b0, 1'b0, 5'b00000);
`endif
    load1(20'h00000);
`ifdef CNT_LZ_BLANK_EN
    push("blank_00000", 1, 20'h00000, 1'b0, 1'b0, 5'b11110);
`else
    push("blank_00000", 1, 20'h00000, 1'b0, 1'b0, 5'b00000);
`endif

    // Asynchronous reset between edges.
    load1(20'h00070);
    nr1 = 1'b0;
    chk("async_reset", 1, 20'h00000, 1'b0, 1'b0);
    tick(); nr1 = 1'b1;

    // Prescaler by 4: ten enabled clocks give two steps.
    load4(20'h00000);
    en4 = 1'b1; repeat (10) tick(); en4 = 1'b0;
    chk("div4_10clk", 2, 20'h00002, 1'b0, 1'b0);

    // Enable gap holds the prescaler, delaying the step by one clock.
    load4(20'h00000);
    en4 = 1'b1; tick(); tick(); en4 = 1'b0; tick(); en4 = 1'b1; tick();
    chk("div4_gap_hold", 2, 20'h00000, 1'b0, 1'b0);
    tick(); en4 = 1'b0;
    chk("div4_gap_step", 2, 20'h00001, 1'b0, 1'b0);

    // Reset mid-prescale aborts the partial count.
    load4(20'h00005);
    en4 = 1'b1; tick(); tick();
    nr4 = 1'b0;
    chk("div4_async_reset", 2, 20'h00000, 1'b0, 1'b0);
    tick(); nr4 = 1'b1;
    tick(); tick(); tick();
    chk("div4_no_early_step", 2, 20'h00000, 1'b0, 1'b0);
    tick(); en4 = 1'b0;
    chk("div4_first_step", 2, 20'h00001, 1'b0, 1'b0);

    tick(); tick();
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
